commit_rob: RTL and testbench
=============================

COMMIT_ROB -- requirements
Module: commit_rob

Interface
REQ-001 Parameter NR_ENTRIES, default 8, SHALL set queue depth; SHALL equal 2**TRANS_ID_BITS.
REQ-002 Parameter NR_WB_PORTS, default 2, SHALL set the number of writeback ports.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 flush_i  input  1  discard all entries.
REQ-006 issue_instr_i  input  scoreboard_entry_t  instruction to enqueue.
REQ-007 issue_valid_i  input  1  issue request.
REQ-008 issue_ready_o  output  1  enqueue possible this cycle.
REQ-009 issue_trans_id_o  output  TRANS_ID_BITS  slot index assigned to the current issue (tail).
REQ-010 wb_valid_i  input  NR_WB_PORTS  result valid per port.
REQ-011 wb_trans_id_i  input  NR_WB_PORTS x TRANS_ID_BITS  target slot.
REQ-012 wb_data_i  input  NR_WB_PORTS x 64  result data.
REQ-013 wb_ex_i  input  NR_WB_PORTS x exception_t  exception raised by the unit.
REQ-014 commit_instr_o  output  2 x scoreboard_entry_t  oldest two entries; .valid means ready to retire.
REQ-015 commit_ack_i  input  2  commit stage retires the corresponding port.
REQ-016 empty_o  output  1  no busy entries.

Function
REQ-017 Storage SHALL be a circular buffer: per-slot busy bit and entry; head, tail, count registers (count width log2(NR_ENTRIES)+1).
REQ-018 issue_ready_o SHALL be (count != NR_ENTRIES) && !flush_i; issue_trans_id_o SHALL equal tail.
REQ-019 On issue_valid_i && issue_ready_o: slot[tail] SHALL be written with issue_instr_i and trans_id=tail, busy set, tail incremented modulo NR_ENTRIES.
REQ-020 Issued entry .valid SHALL be set to issue_instr_i.ex.valid (pre-faulted instruction retires without writeback), else 0.
REQ-021 Writeback port i with wb_valid_i[i] to a busy slot SHALL set .result=wb_data_i[i] and .valid=1 next cycle; if wb_ex_i[i].valid, .ex SHALL be overwritten with wb_ex_i[i].
REQ-022 Writeback to a non-busy slot, or to the slot being issued the same cycle, SHALL be ignored.
REQ-023 Two writeback ports to the same slot in one cycle: higher port index SHALL win.
REQ-024 commit_instr_o[0] SHALL be slot[head] combinationally, .valid = busy && entry.valid.
REQ-025 commit_instr_o[1] SHALL be slot[head+1 mod NR_ENTRIES], .valid = busy && entry.valid && count>=2.
REQ-026 Entries written in cycle N SHALL be visible on commit_instr_o in cycle N+1 (no bypass).
REQ-027 Pop amount SHALL be p0 = commit_ack_i[0] && commit_instr_o[0].valid; p1 = p0 && commit_ack_i[1] && commit_instr_o[1].valid; ack on an invalid port or ack[1] without ack[0] SHALL be ignored.
REQ-028 Popped slots SHALL clear busy and .valid; head SHALL advance by p0+p1 modulo NR_ENTRIES.
REQ-029 count SHALL update as count + issue_fire - p0 - p1 in the same cycle; simultaneous issue and commit when full SHALL NOT issue (ready computed from registered count).
REQ-030 Pointer wrap SHALL be seamless: head/tail crossing NR_ENTRIES-1 -> 0 preserves order.
REQ-031 flush_i SHALL, next cycle, clear all busy and .valid bits and set head=tail=count=0; it overrides same-cycle issue, writeback and commit.
REQ-032 empty_o SHALL equal (count == 0).

Reset
REQ-033 With rst_ni low at a clock edge: head, tail, count = 0, all busy and .valid = 0; takes precedence over flush_i and all inputs.
REQ-034 After reset: issue_ready_o=1, empty_o=1, issue_trans_id_o=0, commit_instr_o[0/1].valid=0.
REQ-035 Reset asserted mid-operation SHALL discard all entries with no retirement.

Verification
REQ-036 Issue 3 instrs (ids 0,1,2), writeback id1 then id0 -> commit_instr_o[0].valid rises only after id0 written; acks 2'b11 retire ids 0,1; count=1.
REQ-037 Fill 8 entries -> issue_ready_o=0; same cycle issue+commit ack[0] on full -> issue rejected, count=7; next cycle ready=1.
REQ-038 Issue 20 instrs with continuous writeback and dual ack -> in-order retirement, ids wrap 7->0, results match writeback data.
REQ-039 Issue entry with ex.valid=1 cause=12 -> commit_instr_o[0].valid=1 next cycle without writeback, ex.cause=12.
REQ-040 Both wb ports target id3 with data 0xA/0xB -> result=0xB; wb to non-busy id5 -> no state change.
REQ-041 5 busy entries, flush_i with concurrent issue and ack -> next cycle empty_o=1, count=0, issue_trans_id_o=0.

Source files
------------

// File: rtl/commit_rob.sv
// In-order commit reorder buffer: circular queue of scoreboard entries filled at issue,
// completed by writeback ports and retired up to two per cycle from the head.

package commit_rob_pkg;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [3:0]               fu;
    logic [7:0]               op;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module commit_rob
  import commit_rob_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = 2**TRANS_ID_BITS,
  parameter int unsigned NR_WB_PORTS = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  scoreboard_entry_t                            issue_instr_i,
  input  logic                                         issue_valid_i,
  output logic                                         issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]                 wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  output scoreboard_entry_t [1:0]                      commit_instr_o,
  input  logic [1:0]                                   commit_ack_i,
  output logic                                         empty_o
);

  localparam int unsigned CNT_BITS = TRANS_ID_BITS + 1;
  localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(NR_ENTRIES);

  scoreboard_entry_t          mem_r [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]      busy_r;
  logic [TRANS_ID_BITS-1:0]   head_r;
  logic [TRANS_ID_BITS-1:0]   tail_r;
  logic [CNT_BITS-1:0]        count_r;

  logic [TRANS_ID_BITS-1:0]   head_p1_s;
  logic                       issue_fire_s;
  logic                       pop0_s;
  logic                       pop1_s;
  scoreboard_entry_t          issue_entry_s;

  assign issue_ready_o    = (count_r != FULL_CNT) && !flush_i;
  assign issue_trans_id_o = tail_r;
  assign empty_o          = (count_r == CNT_BITS'(0));
  assign issue_fire_s     = issue_valid_i && issue_ready_o;
  assign head_p1_s        = head_r + TRANS_ID_BITS'(1);

  // Head-of-queue view, pop decode and the entry image written at issue
  always_comb begin
    commit_instr_o[0]       = mem_r[head_r];
    commit_instr_o[0].valid = busy_r[head_r] && mem_r[head_r].valid;
    commit_instr_o[1]       = mem_r[head_p1_s];
    commit_instr_o[1].valid = busy_r[head_p1_s] && mem_r[head_p1_s].valid
                              && (count_r >= CNT_BITS'(2));
    pop0_s = commit_ack_i[0] && commit_instr_o[0].valid;
    pop1_s = pop0_s && commit_ack_i[1] && commit_instr_o[1].valid;
    issue_entry_s          = issue_instr_i;
    issue_entry_s.trans_id = tail_r;
    // A pre-faulted instruction needs no writeback before it can retire
    issue_entry_s.valid    = issue_instr_i.ex.valid;
  end

  // Queue state: reset/flush, writeback, retirement and issue
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      busy_r  <= '0;
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      // Later ports are assigned last so the highest index wins on a shared slot
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && busy_r[wb_trans_id_i[p]]
            && !(issue_fire_s && (wb_trans_id_i[p] == tail_r))) begin
          mem_r[wb_trans_id_i[p]].result <= wb_data_i[p];
          mem_r[wb_trans_id_i[p]].valid  <= 1'b1;
          if (wb_ex_i[p].valid) begin
            mem_r[wb_trans_id_i[p]].ex <= wb_ex_i[p];
          end
        end
      end
      if (pop0_s) begin
        busy_r[head_r]      <= 1'b0;
        mem_r[head_r].valid <= 1'b0;
      end
      if (pop1_s) begin
        busy_r[head_p1_s]      <= 1'b0;
        mem_r[head_p1_s].valid <= 1'b0;
      end
      if (issue_fire_s) begin
        mem_r[tail_r]  <= issue_entry_s;
        busy_r[tail_r] <= 1'b1;
        tail_r         <= tail_r + TRANS_ID_BITS'(1);
      end
      head_r  <= head_r + TRANS_ID_BITS'(pop0_s) + TRANS_ID_BITS'(pop1_s);
      count_r <= count_r + CNT_BITS'(issue_fire_s) - CNT_BITS'(pop0_s) - CNT_BITS'(pop1_s);
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Self-checking bench for commit_rob: directed vector table, hand-written corner
// sequences and a scoreboarded 20-instruction stream with wrap-around.

module tb_commit_rob;
  import commit_rob_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        flush;
  scoreboard_entry_t           issue_instr;
  logic                        issue_valid;
  logic                        issue_ready;
  logic [2:0]                  issue_tid;
  logic [1:0]                  wb_valid;
  logic [1:0][2:0]             wb_id;
  logic [1:0][63:0]            wb_data;
  exception_t [1:0]            wb_ex;
  scoreboard_entry_t [1:0]     commit_instr;
  logic [1:0]                  commit_ack;
  logic                        empty;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  commit_rob #(.NR_ENTRIES(8), .NR_WB_PORTS(2)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .flush_i          (flush),
    .issue_instr_i    (issue_instr),
    .issue_valid_i    (issue_valid),
    .issue_ready_o    (issue_ready),
    .issue_trans_id_o (issue_tid),
    .wb_valid_i       (wb_valid),
    .wb_trans_id_i    (wb_id),
    .wb_data_i        (wb_data),
    .wb_ex_i          (wb_ex),
    .commit_instr_o   (commit_instr),
    .commit_ack_i     (commit_ack),
    .empty_o          (empty)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  wbv;
    logic [2:0]  wid0, wid1;
    logic [63:0] wd0, wd1;
    logic [1:0]  ack;
    logic        fl;
    logic        e_rdy, e_emp;
    logic [2:0]  e_tid;
    logic        e_c0v, e_c1v;
    logic        chk0;
    logic [2:0]  e_id;
    logic [63:0] e_res;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(input logic iv, input logic [1:0] wbv, input logic [2:0] wid0,
                              input logic [2:0] wid1, input logic [63:0] wd0, input logic [63:0] wd1,
                              input logic [1:0] ack, input logic fl, input logic rdy, input logic emp,
                              input logic [2:0] tid, input logic c0v, input logic c1v,
                              input logic chk0, input logic [2:0] eid, input logic [63:0] eres);
    vec_t v;
    v.iv = iv; v.wbv = wbv; v.wid0 = wid0; v.wid1 = wid1; v.wd0 = wd0; v.wd1 = wd1;
    v.ack = ack; v.fl = fl; v.e_rdy = rdy; v.e_emp = emp; v.e_tid = tid;
    v.e_c0v = c0v; v.e_c1v = c1v; v.chk0 = chk0; v.e_id = eid; v.e_res = eres;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    wb_valid    = 2'b00;
    wb_id       = '0;
    wb_data     = '0;
    wb_ex       = '0;
    commit_ack  = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic issue_n(input int n);
    for (int k = 0; k < n; k++) begin
      idle_inputs();
      issue_valid    = 1'b1;
      issue_instr.pc = 64'(k) + 64'h100;
      step();
    end
    idle_inputs();
  endtask

  logic [2:0]  exp_id_q [$];
  logic [63:0] exp_d_q  [$];
  logic [2:0]  pend_id_q [$];
  logic [63:0] pend_d_q  [$];

  initial begin
    int issued;
    int retired;
    int cyc;
    logic p0;
    logic p1;
    logic [63:0] d;

    // vector table: inputs for the cycle, outputs expected before its clock edge
    vecs[0]  = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[1]  = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[2]  = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[3]  = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[4]  = mk(1'b0, 2'b01, 3'd1, 3'd0, 64'h11, 64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[5]  = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);
    vecs[6]  = mk(1'b0, 2'b01, 3'd0, 3'd0, 64'h10, 64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 3'd0, 64'h0);
    vecs[7]  = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b11, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 3'd0, 64'h10);
    vecs[8]  = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[9]  = mk(1'b0, 2'b01, 3'd2, 3'd0, 64'h12, 64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[10] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b01, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b1, 3'd2, 64'h12);
    vecs[11] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[12] = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[13] = mk(1'b0, 2'b11, 3'd3, 3'd3, 64'hA,  64'hB,  2'b00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[14] = mk(1'b0, 2'b01, 3'd5, 3'd0, 64'hEE, 64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 3'd3, 64'hB);
    vecs[15] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b01, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 3'd3, 64'hB);
    vecs[16] = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[17] = mk(1'b1, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[18] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[19] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);
    vecs[20] = mk(1'b0, 2'b00, 3'd0, 3'd0, 64'h0,  64'h0,  2'b00, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 64'h0);

    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      idle_inputs();
      issue_valid    = vecs[i].iv;
      issue_instr.pc = 64'(i);
      wb_valid       = vecs[i].wbv;
      wb_id[0]       = vecs[i].wid0;
      wb_id[1]       = vecs[i].wid1;
      wb_data[0]     = vecs[i].wd0;
      wb_data[1]     = vecs[i].wd1;
      commit_ack     = vecs[i].ack;
      flush          = vecs[i].fl;
      settle();
      chk($sformatf("v%0d_ready", i), 64'(issue_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d_empty", i), 64'(empty), 64'(vecs[i].e_emp));
      chk($sformatf("v%0d_tid", i), 64'(issue_tid), 64'(vecs[i].e_tid));
      chk($sformatf("v%0d_c0v", i), 64'(commit_instr[0].valid), 64'(vecs[i].e_c0v));
      chk($sformatf("v%0d_c1v", i), 64'(commit_instr[1].valid), 64'(vecs[i].e_c1v));
      if (vecs[i].chk0) begin
        chk($sformatf("v%0d_c0id", i), 64'(commit_instr[0].trans_id), 64'(vecs[i].e_id));
        chk($sformatf("v%0d_c0res", i), commit_instr[0].result, vecs[i].e_res);
      end
      step();
    end

    // full queue: simultaneous issue and commit must not issue
    issue_n(8);
    settle();
    chk("full_ready", 64'(issue_ready), 64'd0);
    chk("full_tid", 64'(issue_tid), 64'd0);
    step();
    wb_valid = 2'b01; wb_id[0] = 3'd0; wb_data[0] = 64'h55;
    step();
    idle_inputs();
    issue_valid = 1'b1;
    commit_ack  = 2'b01;
    settle();
    chk("full_ack_ready", 64'(issue_ready), 64'd0);
    chk("full_ack_c0v", 64'(commit_instr[0].valid), 64'd1);
    step();
    idle_inputs();
    settle();
    chk("after_ack_ready", 64'(issue_ready), 64'd1);
    chk("after_ack_tid", 64'(issue_tid), 64'd0);
    step();
    issue_n(1);
    settle();
    chk("refill_tid", 64'(issue_tid), 64'd1);
    chk("refill_ready", 64'(issue_ready), 64'd0);
    step();
    do_flush();

    // pre-faulted instruction retires without writeback
    issue_valid = 1'b1;
    issue_instr.ex.valid = 1'b1;
    issue_instr.ex.cause = 64'd12;
    step();
    idle_inputs();
    settle();
    chk("exc_c0v", 64'(commit_instr[0].valid), 64'd1);
    chk("exc_cause", commit_instr[0].ex.cause, 64'd12);
    chk("exc_valid", 64'(commit_instr[0].ex.valid), 64'd1);
    step();
    do_flush();

    // flush with concurrent issue and ack on five busy entries
    issue_n(5);
    wb_valid = 2'b11; wb_id[0] = 3'd0; wb_id[1] = 3'd1; wb_data[0] = 64'h1; wb_data[1] = 64'h2;
    step();
    idle_inputs();
    flush = 1'b1; issue_valid = 1'b1; commit_ack = 2'b11;
    step();
    idle_inputs();
    settle();
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_tid", 64'(issue_tid), 64'd0);
    chk("flush_c0v", 64'(commit_instr[0].valid), 64'd0);
    chk("flush_ready", 64'(issue_ready), 64'd1);
    step();

    // reset in the middle of operation discards everything
    issue_n(3);
    wb_valid = 2'b11; wb_id[0] = 3'd0; wb_id[1] = 3'd1;
    step();
    idle_inputs();
    rst_n = 1'b0; issue_valid = 1'b1; commit_ack = 2'b11;
    step();
    rst_n = 1'b1;
    idle_inputs();
    settle();
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_tid", 64'(issue_tid), 64'd0);
    chk("rst_c0v", 64'(commit_instr[0].valid), 64'd0);
    chk("rst_c1v", 64'(commit_instr[1].valid), 64'd0);
    step();

    // streaming: 20 instructions, writeback one cycle after issue, dual ack
    issued = 0; retired = 0; cyc = 0;
    while (retired < 20 && cyc < 300) begin
      idle_inputs();
      commit_ack = 2'b11;
      for (int p = 0; p < 2; p++) begin
        if (pend_id_q.size() > 0) begin
          wb_valid[p] = 1'b1;
          wb_id[p]    = pend_id_q.pop_front();
          wb_data[p]  = pend_d_q.pop_front();
        end
      end
      if (issued < 20 && issue_ready) begin
        issue_valid    = 1'b1;
        issue_instr.pc = 64'(issued);
        d = 64'hD000_0000 + 64'(issued);
        exp_id_q.push_back(3'(issued));
        exp_d_q.push_back(d);
        pend_id_q.push_back(3'(issued));
        pend_d_q.push_back(d);
        issued++;
      end
      settle();
      p0 = commit_instr[0].valid;
      p1 = p0 && commit_instr[1].valid;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 && p0) || (k == 1 && p1)) begin
          if (exp_id_q.size() == 0) begin
            chk("sb_unexpected_retire", 64'd1, 64'd0);
          end else begin
            chk($sformatf("sb_id%0d", retired), 64'(commit_instr[k].trans_id), 64'(exp_id_q.pop_front()));
            chk($sformatf("sb_res%0d", retired), commit_instr[k].result, exp_d_q.pop_front());
          end
          retired++;
        end
      end
      step();
      cyc++;
    end
    chk("stream_retired", 64'(retired), 64'd20);
    idle_inputs();
    settle();
    chk("stream_empty", 64'(empty), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
